mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single four-banked main memory between the instruction-cache controller (I side) and the data-cache controller (D side).
- Each cache controller drives rd/wr/addr/data and obeys a stall input, exactly as it would toward memory.
- The arbiter grants whole line transactions (write-back plus allocate sequences), holds the grant while the owner keeps requesting, and routes returning read data to its issuer through a tag pipeline.

Parameters:
- RD_LAT, 2, memory read latency in cycles from an accepted rd (mem_rd & ~mem_stall) to valid mem_data_out; legal range 1-4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_rd  in  1  I-side read request
- i_wr  in  1  I-side write request
- i_addr  in  16  I-side address
- i_data_in  in  16  I-side write data
- i_data_out  out  16  read data returned to I side
- i_stall  out  1  stall to I side
- d_rd  in  1  D-side read request
- d_wr  in  1  D-side write request
- d_addr  in  16  D-side address
- d_data_in  in  16  D-side write data
- d_data_out  out  16  read data returned to D side
- d_stall  out  1  stall to D side
- mem_rd  out  1  memory read
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data
- mem_stall  in  1  memory busy/bank-conflict stall
- mem_err  in  1  memory error
- gnt_i  out  1  I side owns memory (registered state decode)
- gnt_d  out  1  D side owns memory
- err  out  1  protocol/memory error flag

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-low, sampled on the rising edge of clk.
- While rst=0 at an edge, the next state is:
  - state=IDLE, last=I, tag pipeline all invalid.
  - This gives gnt_i=gnt_d=0, mem_rd=mem_wr=0, mem_addr=mem_data_in=0, i_data_out=d_data_out=0 and err=0.
  - i_stall/d_stall follow the IDLE rule below.
- Reset mid-transaction: any grant and any in-flight read tags are dropped, and the late data is discarded.
- States: IDLE, GNT_I, GNT_D. A 2-bit state register; the encoding 2'b11 is illegal (see err).
- IDLE:
  - Memory is not driven. Each requester with rd|wr gets stall=1 (one-cycle arbitration bubble).
  - Only I requests -> GNT_I. Only D requests -> GNT_D. Neither requests -> IDLE.
  - Both request -> round-robin: grant the side that is not `last`. `last` updates on every grant.
- GNT_X (X = owner):
  - mem_rd/mem_wr/mem_addr/mem_data_in = the owner's rd/wr/addr/data_in.
  - Owner's stall = mem_stall.
  - Non-owner's stall = its rd|wr; the non-owner's request is held, never dropped.
  - Owner rd|wr=1 -> stay in GNT_X (grant held across WB0-3 into ALLO0-3 with no release).
  - Owner rd|wr=0 -> IDLE. The memory sees no access that cycle.
- Latency: a fresh request from an idle arbiter reaches memory 1 cycle later. A handover to the waiting side costs 2 cycles (release cycle + IDLE arbitration cycle).
- Read routing:
  - On mem_rd & ~mem_stall, push {valid=1, owner} into an RD_LAT-deep shift register; otherwise push invalid.
  - When the tail entry is valid: its owner's data_out = mem_data_out and the other side's data_out = 0.
  - When the tail entry is invalid: both data_out = 0.
  - Routing is independent of the current grant, so ALLO4/ALLO5-style trailing cycles after release still receive their data.
- err (combinational) = mem_err while granted, OR (owner rd & wr both 1), OR illegal state.
  - In the illegal state, the next state is IDLE.
  - err never changes the grant.
- The non-owner's rd/wr/addr never reach memory.

Optional Feature:
- Macro MEM_ARB_DPRIO_EN.
- Defined: fixed priority. D always wins simultaneous requests in IDLE; `last` is not implemented.
- Undefined: round-robin as above.
- Grant holding and release rules are identical in both builds.

Test Plan:
- Single I line fill:
  - Stimulus: i_rd=1 for 4 accepted cycles at addr 0x1230/0x1232/0x1234/0x1236, mem_stall=0, RD_LAT=2.
  - Response: gnt_i=1 from cycle 1; mem_addr follows the 4 addresses; i_data_out = memory words on cycles 3-6; d_data_out=0 throughout.
- Simultaneous requests after reset:
  - Stimulus: i_rd=d_rd=1.
  - Response (round-robin): GNT_D first (last=I); i_stall=1 until D drops; GNT_I 2 cycles after D's release.
  - Response (MEM_ARB_DPRIO_EN): D is granted every time.
- Write-back then allocate:
  - Stimulus: D holds wr for 4 cycles, then rd for 4 cycles, while I requests.
  - Response: no IDLE between wr and rd; grant stays D; I is stalled for the whole 8 accepted accesses.
- Memory stall:
  - Stimulus: mem_stall=1 for 3 cycles mid-burst.
  - Response: owner stall=1 for those cycles; no tag is pushed; data arrives RD_LAT cycles after each accepted read only.
- Handover with in-flight reads:
  - Stimulus: D releases right after its last accepted read, and I is granted.
  - Response: the last 2 returned words appear on d_data_out, not i_data_out.
- Reset mid-burst and error:
  - Stimulus: rst=0 for one edge during GNT_I.
  - Response: next cycle gnt_i=0, all outputs 0, pending read data discarded.
  - Stimulus: owner rd=wr=1.
  - Response: err=1 that cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, the two cache controllers and main memory.
// slave: arbiter view. master: environment view (both caches plus memory).
interface mem_arbiter_if;
  // I-side cache controller
  logic        i_rd;
  logic        i_wr;
  logic [15:0] i_addr;
  logic [15:0] i_data_in;
  logic [15:0] i_data_out;
  logic        i_stall;
  // D-side cache controller
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic [15:0] d_data_out;
  logic        d_stall;
  // Main memory
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_stall;
  logic        mem_err;

  modport slave (
    input  i_rd, i_wr, i_addr, i_data_in,
    output i_data_out, i_stall,
    input  d_rd, d_wr, d_addr, d_data_in,
    output d_data_out, d_stall,
    output mem_rd, mem_wr, mem_addr, mem_data_in,
    input  mem_data_out, mem_stall, mem_err
  );

  modport master (
    output i_rd, i_wr, i_addr, i_data_in,
    input  i_data_out, i_stall,
    output d_rd, d_wr, d_addr, d_data_in,
    input  d_data_out, d_stall,
    input  mem_rd, mem_wr, mem_addr, mem_data_in,
    output mem_data_out, mem_stall, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing main memory between the I-cache and D-cache controllers.
// Grants whole line transactions, holds the grant while the owner keeps
// requesting, and routes returning read data to its issuer via a tag pipe.
// Define MEM_ARB_DPRIO_EN for fixed D-side priority; default is round-robin.
module mem_arbiter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus,
  output logic            gnt_i,
  output logic            gnt_d,
  output logic            err
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGntI = 2'b01,
    StGntD = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic i_req, d_req;
  assign i_req = bus.i_rd | bus.i_wr;
  assign d_req = bus.d_rd | bus.d_wr;

  // Read tag pipeline: entry RD_LAT-1 lines up with mem_data_out.
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_own_q, tag_own_d;  // 1: issued by D side
  logic              push_vld;

`ifndef MEM_ARB_DPRIO_EN
  logic last_q, last_d;  // 1: D side got the most recent grant

  // Round-robin history register
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arbitrate in idle, hold grant while the owner requests
  always_comb begin
    state_d = state_q;
`ifndef MEM_ARB_DPRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
`ifdef MEM_ARB_DPRIO_EN
          state_d = StGntD;
`else
          state_d = last_q ? StGntI : StGntD;
          last_d  = ~last_q;
`endif
        end else if (i_req) begin
          state_d = StGntI;
`ifndef MEM_ARB_DPRIO_EN
          last_d  = 1'b0;
`endif
        end else if (d_req) begin
          state_d = StGntD;
`ifndef MEM_ARB_DPRIO_EN
          last_d  = 1'b1;
`endif
        end
      end
      StGntI: if (!i_req) state_d = StIdle;
      StGntD: if (!d_req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: route owner to memory, stall everyone else
  always_comb begin
    gnt_i           = 1'b0;
    gnt_d           = 1'b0;
    err             = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = 16'h0000;
    bus.mem_data_in = 16'h0000;
    bus.i_stall     = i_req;
    bus.d_stall     = d_req;
    case (state_q)
      StIdle: ;
      StGntI: begin
        gnt_i           = 1'b1;
        bus.mem_rd      = bus.i_rd;
        bus.mem_wr      = bus.i_wr;
        bus.mem_addr    = bus.i_addr;
        bus.mem_data_in = bus.i_data_in;
        bus.i_stall     = bus.mem_stall;
        err             = bus.mem_err | (bus.i_rd & bus.i_wr);
      end
      StGntD: begin
        gnt_d           = 1'b1;
        bus.mem_rd      = bus.d_rd;
        bus.mem_wr      = bus.d_wr;
        bus.mem_addr    = bus.d_addr;
        bus.mem_data_in = bus.d_data_in;
        bus.d_stall     = bus.mem_stall;
        err             = bus.mem_err | (bus.d_rd & bus.d_wr);
      end
      default: err = 1'b1;
    endcase
  end

  // Tag pipeline next state: push on every accepted read
  always_comb begin
    push_vld     = bus.mem_rd & ~bus.mem_stall;
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = push_vld;
    tag_own_d[0] = (state_q == StGntD);
    for (int i = 1; i < int'(RD_LAT); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // Tag pipeline register; reset drops in-flight tags so late data is discarded
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  // Read data return, independent of the current grant
  always_comb begin
    bus.i_data_out = 16'h0000;
    bus.d_data_out = 16'h0000;
    if (tag_vld_q[RD_LAT-1]) begin
      if (tag_own_q[RD_LAT-1]) bus.d_data_out = bus.mem_data_out;
      else                     bus.i_data_out = bus.mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cache-like requesters and a latency memory drive the
// DUT; a transaction-level model predicts every output each cycle.
module tb_mem_arbiter;
  localparam int unsigned RdLat = 2;

  logic clk = 1'b0;
  logic rst;
  logic gnt_i, gnt_d, err;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .RD_LAT(RdLat)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .gnt_i(gnt_i),
    .gnt_d(gnt_d),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Model: owner 0 none, 1 I, 2 D; last 1 means D was granted last
  typedef struct {int due; bit is_d; logic [15:0] data;} ret_t;
  ret_t pend[$];
  int   m_owner = 0;
  bit   m_last  = 1'b0;

  // Memory environment return queue
  typedef struct {int due; logic [15:0] data;} mret_t;
  mret_t mq[$];

  // Requesters: side 0 = I, 1 = D
  bit          exp_stall[2];
  int          tot[2], k[2], nwr[2], gap[2];
  logic [15:0] base[2];
  bit          force_rw, force_rst;
  int          stall_left;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic start_burst(input int s, input int nw, input logic [15:0] b);
    nwr[s]  = nw;
    tot[s]  = nw + 4;
    k[s]    = 0;
    base[s] = b;
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance the model
  task automatic step(input logic ir, iw, input logic [15:0] ia, idi,
                      input logic dr, dw, input logic [15:0] da, ddi,
                      input logic ms, me, rn);
    logic ireq, dreq, e_gi, e_gd, e_rd, e_wr, e_is, e_ds, e_err;
    logic [15:0] e_addr, e_wd, e_id, e_dd;
    bus.i_rd = ir; bus.i_wr = iw; bus.i_addr = ia; bus.i_data_in = idi;
    bus.d_rd = dr; bus.d_wr = dw; bus.d_addr = da; bus.d_data_in = ddi;
    bus.mem_stall = ms; bus.mem_err = me; rst = rn;
    while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
    bus.mem_data_out = 16'($urandom);
    if (mq.size() > 0 && mq[0].due == cyc) bus.mem_data_out = mq[0].data;

    ireq = ir | iw; dreq = dr | dw;
    e_gi = 0; e_gd = 0; e_rd = 0; e_wr = 0; e_err = 0;
    e_addr = 0; e_wd = 0; e_is = ireq; e_ds = dreq;
    if (m_owner == 1) begin
      e_gi = 1; e_rd = ir; e_wr = iw; e_addr = ia; e_wd = idi; e_is = ms;
      e_err = me | (ir & iw);
    end else if (m_owner == 2) begin
      e_gd = 1; e_rd = dr; e_wr = dw; e_addr = da; e_wd = ddi; e_ds = ms;
      e_err = me | (dr & dw);
    end
    e_id = 0; e_dd = 0;
    foreach (pend[j]) if (pend[j].due == cyc) begin
      if (pend[j].is_d) e_dd = pend[j].data;
      else              e_id = pend[j].data;
    end

    @(negedge clk);
    check_eq("gnt_i", gnt_i, e_gi);
    check_eq("gnt_d", gnt_d, e_gd);
    check_eq("err", err, e_err);
    check_eq("mem_rd", bus.mem_rd, e_rd);
    check_eq("mem_wr", bus.mem_wr, e_wr);
    check_eq("mem_addr", bus.mem_addr, e_addr);
    check_eq("mem_data_in", bus.mem_data_in, e_wd);
    check_eq("i_stall", bus.i_stall, e_is);
    check_eq("d_stall", bus.d_stall, e_ds);
    check_eq("i_data_out", bus.i_data_out, e_id);
    check_eq("d_data_out", bus.d_data_out, e_dd);
    exp_stall[0] = e_is;
    exp_stall[1] = e_ds;

    // Memory answers whatever the DUT actually issued
    if (bus.mem_rd === 1'b1 && !ms) mq.push_back('{cyc + int'(RdLat), mem_word(bus.mem_addr)});

    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    if (!rn) begin
      m_owner = 0; m_last = 0; pend.delete();
    end else begin
      if (e_rd && !ms) pend.push_back('{cyc + int'(RdLat), m_owner == 2, mem_word(e_addr)});
      if (m_owner == 0) begin
        if (ireq && dreq) begin
`ifdef MEM_ARB_DPRIO_EN
          m_owner = 2;
`else
          m_owner = m_last ? 1 : 2;
`endif
        end else if (ireq) m_owner = 1;
        else if (dreq) m_owner = 2;
        if (m_owner != 0) m_last = (m_owner == 2);
      end else if (m_owner == 1 && !ireq) m_owner = 0;
      else if (m_owner == 2 && !dreq) m_owner = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Run n cycles of requester activity; rnd adds random bursts and faults
  task automatic run(input int n, input bit rnd);
    logic r[2], w[2];
    logic [15:0] a[2], wd[2];
    logic ms, me, rn, inj;
    for (int c = 0; c < n; c++) begin
      inj = force_rw || (rnd && $urandom_range(96) == 0);
      for (int s = 0; s < 2; s++) begin
        if (k[s] >= tot[s]) begin
          if (gap[s] > 0) gap[s]--;
          else if (rnd && $urandom_range(3) == 0)
            start_burst(s, ($urandom_range(1) == 1) ? 4 : 0, 16'($urandom) & 16'hFFF0);
        end
        r[s] = 0; w[s] = 0; a[s] = 0; wd[s] = 16'($urandom);
        if (k[s] < tot[s]) begin
          w[s] = (k[s] < nwr[s]);
          r[s] = !w[s];
          a[s] = base[s] + 16'(2 * (k[s] % 4));
          if (inj) begin r[s] = 1; w[s] = 1; end
        end
      end
      force_rw = 0;
      ms = rnd ? ($urandom_range(4) == 0) : (stall_left > 0);
      if (stall_left > 0) stall_left--;
      me = rnd && ($urandom_range(39) == 0);
      rn = !(force_rst || (rnd && $urandom_range(399) == 0));
      force_rst = 0;
      step(r[0], w[0], a[0], wd[0], r[1], w[1], a[1], wd[1], ms, me, rn);
      for (int s = 0; s < 2; s++) begin
        if ((r[s] | w[s]) && !exp_stall[s]) begin
          k[s]++;
          if (k[s] == tot[s]) gap[s] = 1 + $urandom_range(2);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.i_rd = 0; bus.i_wr = 0; bus.i_addr = 0; bus.i_data_in = 0;
    bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_data_in = 0;
    bus.mem_stall = 0; bus.mem_err = 0; bus.mem_data_out = 0;
    for (int s = 0; s < 2; s++) begin
      tot[s] = 0; k[s] = 0; nwr[s] = 0; gap[s] = 0; base[s] = 0;
    end
    force_rw = 0; force_rst = 0; stall_left = 0;
    repeat (2) @(posedge clk);
    #1;

    run(2, 0);                                          // reset state
    start_burst(0, 0, 16'h1230); run(10, 0);            // single I line fill
    force_rst = 1; run(1, 0);                           // simultaneous after reset
    start_burst(0, 0, 16'h2000); start_burst(1, 0, 16'h3000); run(20, 0);
    start_burst(1, 4, 16'h4400); start_burst(0, 0, 16'h5500); run(25, 0);  // WB + alloc
    start_burst(0, 0, 16'h6600); run(3, 0);             // memory stall mid-burst
    stall_left = 3; run(12, 0);
    start_burst(1, 0, 16'h7700); run(2, 0);             // handover with reads in flight
    start_burst(0, 0, 16'h7800); run(15, 0);
    start_burst(0, 0, 16'h8800); run(4, 0);             // reset mid-burst
    force_rst = 1; run(1, 0); run(8, 0);
    start_burst(0, 0, 16'h9900); run(2, 0);             // owner rd & wr together
    force_rw = 1; run(1, 0); run(8, 0);

    run(4000, 1);
    run(30, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
